// File: rtl/mesm6_operand_loader.sv
// mesm6_operand_loader
//
// Assembles the 48-bit accumulator and mask operands for the MESM-6 pack/unpack
// stage from the slide switches, one chunk per load-button press. The chunk
// layout is LSB first: 10+10+10+10+8 bits. When both words are complete, they
// are held and presented through a valid/ready handshake.
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   sw           switch data, sampled only on a capture cycle
//   load_btn     raw push-button level, active-high (synchronised internally)
//   clear        synchronous clear; wins over a strobe and over out_ready
//   out_ready    consumer accepts the operand pair
//   acc, mask    assembled operands
//   out_valid    acc/mask complete and stable
//   chunk_idx    index (0..4) of the next chunk to be written
//   loading_mask 0 = next chunk goes to acc, 1 = next chunk goes to mask
module mesm6_operand_loader (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [9:0]  sw,
    input  logic        load_btn,
    input  logic        clear,
    input  logic        out_ready,
    output logic [47:0] acc,
    output logic [47:0] mask,
    output logic        out_valid,
    output logic [2:0]  chunk_idx,
    output logic        loading_mask
);

    localparam int unsigned CHUNKS = 5;
    localparam logic [2:0] LastIdx = 3'(CHUNKS - 1);

    typedef enum logic [1:0] {StLoadAcc, StLoadMask, StPresent} state_e;

    state_e      state_q, state_d;
    logic [2:0]  idx_q, idx_d;
    logic [47:0] acc_q, acc_d;
    logic [47:0] mask_q, mask_d;
    logic        s1_q, s2_q, s3_q;
    logic        strobe;

    // Overwrite only the addressed field; the top chunk takes sw[7:0].
    function automatic logic [47:0] put_chunk(input logic [47:0] word,
                                              input logic [2:0]  idx,
                                              input logic [9:0]  data);
        logic [47:0] res;
        res = word;
        case (idx)
            3'd0:    res[9:0]   = data;
            3'd1:    res[19:10] = data;
            3'd2:    res[29:20] = data;
            3'd3:    res[39:30] = data;
            3'd4:    res[47:40] = data[7:0];
            default: res = word;
        endcase
        return res;
    endfunction

    // s1/s2 synchronise the button; s3 holds last level for rising-edge detect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= load_btn;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign strobe = s2_q & ~s3_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StLoadAcc;
            idx_q   <= 3'd0;
            acc_q   <= 48'd0;
            mask_q  <= 48'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
            mask_q  <= mask_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        acc_d   = acc_q;
        mask_d  = mask_q;
        if (clear) begin
            state_d = StLoadAcc;
            idx_d   = 3'd0;
            acc_d   = 48'd0;
            mask_d  = 48'd0;
        end else begin
            unique case (state_q)
                StLoadAcc: begin
                    if (strobe) begin
                        acc_d = put_chunk(acc_q, idx_q, sw);
                        if (idx_q == LastIdx) begin
                            state_d = StLoadMask;
                            idx_d   = 3'd0;
                        end else begin
                            idx_d = idx_q + 3'd1;
                        end
                    end
                end
                StLoadMask: begin
                    if (strobe) begin
                        mask_d = put_chunk(mask_q, idx_q, sw);
                        if (idx_q == LastIdx) begin
                            state_d = StPresent;
                            idx_d   = 3'd0;
                        end else begin
                            idx_d = idx_q + 3'd1;
                        end
                    end
                end
                StPresent: begin
                    // Strobes are dropped here; operands stay frozen until taken.
                    if (out_ready) begin
                        state_d = StLoadAcc;
                    end
                end
                default: begin
                    state_d = StLoadAcc;
                    idx_d   = 3'd0;
                end
            endcase
        end
    end

    assign acc          = acc_q;
    assign mask         = mask_q;
    assign chunk_idx    = idx_q;
    assign out_valid    = (state_q == StPresent);
    assign loading_mask = (state_q == StLoadMask);

endmodule

// File: tb/tb_mesm6_operand_loader.sv
module tb_mesm6_operand_loader;

    logic        clk;
    logic        rst_n;
    logic [9:0]  sw;
    logic        load_btn;
    logic        clear;
    logic        out_ready;
    logic [47:0] acc;
    logic [47:0] mask;
    logic        out_valid;
    logic [2:0]  chunk_idx;
    logic        loading_mask;

    mesm6_operand_loader dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sw           (sw),
        .load_btn     (load_btn),
        .clear        (clear),
        .out_ready    (out_ready),
        .acc          (acc),
        .mask         (mask),
        .out_valid    (out_valid),
        .chunk_idx    (chunk_idx),
        .loading_mask (loading_mask)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: number of chunks captured so far (0..10) plus the two words.
    int          n_cap;
    logic [47:0] acc_m;
    logic [47:0] mask_m;

    task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [47:0] put(input logic [47:0] w, input int idx,
                                        input logic [9:0] v);
        int width;
        logic [47:0] fm;
        width = (idx == 4) ? 8 : 10;
        fm = ((48'd1 << width) - 48'd1) << (idx * 10);
        return (w & ~fm) | ((48'(v) << (idx * 10)) & fm);
    endfunction

    task automatic model_reset();
        n_cap  = 0;
        acc_m  = '0;
        mask_m = '0;
    endtask

    task automatic model_capture(input logic [9:0] v);
        if (n_cap < 5) acc_m = put(acc_m, n_cap, v);
        else if (n_cap < 10) mask_m = put(mask_m, n_cap - 5, v);
        if (n_cap < 10) n_cap++;
    endtask

    task automatic check_all(input string tag);
        check({tag, ".acc"}, acc, acc_m);
        check({tag, ".mask"}, mask, mask_m);
        check({tag, ".valid"}, 48'(out_valid), 48'(n_cap == 10));
        check({tag, ".idx"}, 48'(chunk_idx), 48'((n_cap == 10) ? 0 : n_cap % 5));
        check({tag, ".lm"}, 48'(loading_mask), 48'(n_cap >= 5 && n_cap < 10));
    endtask

    // One press: button high for 'hold' cycles, then settle well past capture.
    task automatic press(input logic [9:0] v, input int hold);
        @(negedge clk);
        sw = v;
        load_btn = 1'b1;
        repeat (hold) @(negedge clk);
        load_btn = 1'b0;
        repeat (3) @(negedge clk);
        model_capture(v);
    endtask

    task automatic accept();
        @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        if (n_cap == 10) n_cap = 0;
    endtask

    task automatic do_clear();
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        model_reset();
    endtask

    logic [9:0] dir_vals [10] = '{10'h001, 10'h002, 10'h004, 10'h008, 10'h3F0,
                                  10'h3FF, 10'h3FF, 10'h3FF, 10'h3FF, 10'h0FF};

    initial begin
        rst_n = 1'b0;
        sw = '0;
        load_btn = 1'b0;
        clear = 1'b0;
        out_ready = 1'b0;
        model_reset();
        #12;
        @(negedge clk);
        rst_n = 1'b1;

        // Idle after reset.
        for (int i = 0; i < 5; i++) begin
            repeat (20) @(negedge clk);
            check_all("idle");
        end

        // Directed fill; last press checked for exact latency.
        for (int i = 0; i < 9; i++) begin
            press(dir_vals[i], 1);
            check_all("fill");
        end
        @(negedge clk);
        sw = dir_vals[9];
        load_btn = 1'b1;
        @(negedge clk);   // after edge k (rise sampled)
        load_btn = 1'b0;
        @(negedge clk);   // after edge k+1
        check("lat.valid_k1", 48'(out_valid), 48'd0);
        check("lat.idx_k1", 48'(chunk_idx), 48'd4);
        @(negedge clk);   // after edge k+2
        check("lat.valid_k2", 48'(out_valid), 48'd1);
        model_capture(dir_vals[9]);
        check("dir.acc", acc, 48'hF0_0200_4008_01);
        check("dir.mask", mask, 48'hFFFF_FFFF_FFFF);
        check_all("dir");

        // Presses while presenting are discarded.
        for (int i = 0; i < 3; i++) press(10'h155, 1);
        check_all("present");
        accept();
        check_all("accepted");
        accept();  // out_ready with out_valid low: no effect
        check_all("ready_idle");

        // Clear coinciding with a strobe.
        for (int i = 0; i < 3; i++) press(10'($urandom), 1);
        check_all("pre_clear");
        @(negedge clk);
        sw = 10'h2AA;
        load_btn = 1'b1;
        @(negedge clk);   // after edge k
        @(negedge clk);   // after edge k+1, strobe high
        clear = 1'b1;
        @(negedge clk);   // after edge k+2
        clear = 1'b0;
        load_btn = 1'b0;
        model_reset();
        check_all("clear_strobe");
        repeat (3) @(negedge clk);
        check_all("clear_after");

        // Long hold gives one capture; spaced 1-cycle pulses give one each.
        press(10'h3C3, 1000);
        check_all("hold");
        for (int i = 0; i < 6; i++) begin
            press(10'($urandom), 1);
            check_all("burst");
        end

        // Random mix of presses, accepts and clears.
        for (int i = 0; i < 80; i++) begin
            int op;
            op = int'($urandom_range(0, 9));
            if (op < 7) press(10'($urandom), int'($urandom_range(1, 4)));
            else if (op < 9) accept();
            else do_clear();
            check_all("rand");
        end

        // Async reset mid-word.
        do_clear();
        for (int i = 0; i < 7; i++) press(10'($urandom), 1);
        check_all("pre_rst");
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) press(10'($urandom), 1);
        check_all("post_rst");
        accept();
        check_all("post_rst_acc");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
